// File: rtl/pmp_seq_checker.sv
// pmp_seq_checker: sequential PMP permission checker.
// One PMP entry is decoded per cycle, lowest index first, through a single
// shared decoder. The walk stops at the first matching active entry or after
// the last entry. A fault/allow response is then held until it is accepted.
module pmp_seq_checker #(
    parameter int PA_BITS     = 56,
    parameter int PMP_ENTRIES = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ReqValid,
    output logic                                  ReqReady,
    input  logic [PA_BITS-1:0]                    ReqPA,
    input  logic [1:0]                            ReqSize,
    input  logic [1:0]                            ReqType,
    input  logic [1:0]                            ReqPriv,
    input  logic [8*PMP_ENTRIES-1:0]              PMPCfgAll,
    input  logic [(PA_BITS-2)*PMP_ENTRIES-1:0]    PMPAdrAll,
    output logic                                  Busy,
    output logic                                  RspValid,
    input  logic                                  RspReady,
    output logic                                  RspFault,
    output logic                                  RspMatch,
    output logic [((PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1)-1:0] RspEntry
);

    localparam int ADR_W = PA_BITS - 2;
    localparam int IDX_W = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PMP_ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WALK = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Required permission bit for the access type (type 11 behaves as read),
    // then the fault decision for a matched or unmatched walk.
    function automatic logic access_fault(
        input logic       hit,
        input logic [7:0] cfg,
        input logic [1:0] typ,
        input logic [1:0] priv,
        input logic       any_act
    );
        logic need;
        logic not_m;
        not_m = (priv != 2'b11);
        case (typ)
            2'b01:   need = cfg[1];
            2'b10:   need = cfg[2];
            default: need = cfg[0];
        endcase
        if (hit) begin
            access_fault = (not_m | cfg[7]) & ~need;
        end else begin
            access_fault = not_m & any_act;
        end
    endfunction

    state_t               state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [PA_BITS-1:0]   pa_r;
    logic [1:0]           size_r;
    logic [1:0]           type_r;
    logic [1:0]           priv_r;
    logic                 pa_ge_prev_r;
    logic                 any_active_r;
    logic                 req_ready_r;
    logic                 busy_r;
    logic                 rsp_valid_r;
    logic                 rsp_fault_r;
    logic                 rsp_match_r;
    logic [IDX_W-1:0]     rsp_entry_r;

    logic [7:0]           cfg_s;
    logic [ADR_W-1:0]     adr_s;
    logic [1:0]           mode_s;
    logic [PA_BITS-1:0]   base_s;
    logic [ADR_W-1:0]     napot_mask_s;
    logic [PA_BITS-1:0]   mask_s;
    logic                 napot_hit_s;
    logic                 tor_hit_s;
    logic                 hit_s;
    logic                 active_s;
    logic                 last_s;

    // Select the entry under examination from the live CSR buses.
    always_comb begin
        cfg_s = PMPCfgAll[int'(idx_r)*8 +: 8];
        adr_s = PMPAdrAll[int'(idx_r)*ADR_W +: ADR_W];
    end

    // Shared per-entry address decoder (TOR / NA4 / NAPOT).
    always_comb begin
        mode_s       = cfg_s[4:3];
        active_s     = (mode_s != 2'b00);
        base_s       = {adr_s, 2'b00};
        // Trailing ones of a NAPOT address flip on +1, exposing the region size;
        // NA4 adds zero so only the two low bits are don't-care.
        napot_mask_s = (adr_s + {{(ADR_W-1){1'b0}}, (mode_s == 2'b11)}) ^ adr_s;
        mask_s       = {napot_mask_s, 2'b11};
        if (size_r == 2'b11) begin
            mask_s[2] = 1'b1;
        end else begin
            mask_s[2] = 1'b0;
        end
        napot_hit_s  = (((pa_r ^ {adr_s & ~napot_mask_s, 2'b00}) & ~mask_s)
                        == {PA_BITS{1'b0}});
        tor_hit_s    = pa_ge_prev_r & (pa_r < base_s);
        case (mode_s)
            2'b00:   hit_s = 1'b0;
            2'b01:   hit_s = tor_hit_s;
            default: hit_s = napot_hit_s;
        endcase
        last_s       = (idx_r == LAST_IDX);
    end

    // Control FSM: request capture, entry walk and held response, all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_W{1'b0}};
            pa_r         <= {PA_BITS{1'b0}};
            size_r       <= 2'b00;
            type_r       <= 2'b00;
            priv_r       <= 2'b00;
            pa_ge_prev_r <= 1'b1;
            any_active_r <= 1'b0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_fault_r  <= 1'b0;
            rsp_match_r  <= 1'b0;
            rsp_entry_r  <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ReqValid) begin
                        pa_r         <= ReqPA;
                        size_r       <= ReqSize;
                        type_r       <= ReqType;
                        priv_r       <= ReqPriv;
                        idx_r        <= {IDX_W{1'b0}};
                        pa_ge_prev_r <= 1'b1;
                        any_active_r <= 1'b0;
                        req_ready_r  <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= ST_WALK;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_WALK: begin
                    pa_ge_prev_r <= (pa_r >= base_s);
                    any_active_r <= any_active_r | active_s;
                    idx_r        <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    if (hit_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_match_r <= 1'b1;
                        rsp_entry_r <= idx_r;
                        rsp_fault_r <= access_fault(1'b1, cfg_s, type_r, priv_r, 1'b0);
                        state_r     <= ST_RESP;
                    end else if (last_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_match_r <= 1'b0;
                        rsp_entry_r <= {IDX_W{1'b0}};
                        rsp_fault_r <= access_fault(1'b0, cfg_s, type_r, priv_r,
                                                    any_active_r | active_s);
                        state_r     <= ST_RESP;
                    end else begin
                        state_r     <= ST_WALK;
                    end
                end
                ST_RESP: begin
                    if (RspReady) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ReqReady = req_ready_r;
    assign Busy     = busy_r;
    assign RspValid = rsp_valid_r;
    assign RspFault = rsp_fault_r;
    assign RspMatch = rsp_match_r;
    assign RspEntry = rsp_entry_r;

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Directed self-checking bench for pmp_seq_checker (PA_BITS=56, 16 entries).
module tb_pmp_seq_checker;

    logic          clk;
    logic          reset_n;
    logic          ReqValid;
    logic          ReqReady;
    logic [55:0]   ReqPA;
    logic [1:0]    ReqSize;
    logic [1:0]    ReqType;
    logic [1:0]    ReqPriv;
    logic [127:0]  PMPCfgAll;
    logic [863:0]  PMPAdrAll;
    logic          Busy;
    logic          RspValid;
    logic          RspReady;
    logic          RspFault;
    logic          RspMatch;
    logic [3:0]    RspEntry;

    int checks;
    int errors;
    int lat;
    logic seen;

    pmp_seq_checker #(.PA_BITS(56), .PMP_ENTRIES(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqPA     (ReqPA),
        .ReqSize   (ReqSize),
        .ReqType   (ReqType),
        .ReqPriv   (ReqPriv),
        .PMPCfgAll (PMPCfgAll),
        .PMPAdrAll (PMPAdrAll),
        .Busy      (Busy),
        .RspValid  (RspValid),
        .RspReady  (RspReady),
        .RspFault  (RspFault),
        .RspMatch  (RspMatch),
        .RspEntry  (RspEntry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        PMPCfgAll = '0;
        PMPAdrAll = '0;
    endtask

    task automatic set_entry(input int i, input logic [7:0] c, input logic [53:0] a);
        PMPCfgAll[8*i +: 8]   = c;
        PMPAdrAll[54*i +: 54] = a;
    endtask

    // Present a request just after a rising edge; it is accepted at the next edge (E0).
    task automatic issue(input logic [55:0] pa, input logic [1:0] sz,
                         input logic [1:0] typ, input logic [1:0] priv);
        ReqPA    = pa;
        ReqSize  = sz;
        ReqType  = typ;
        ReqPriv  = priv;
        ReqValid = 1'b1;
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
    endtask

    // Count edges after E0 until RspValid is seen, bounded.
    task automatic wait_rsp(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            n++;
            #1;
            if (RspValid) break;
        end
    endtask

    task automatic finish_rsp(input string tag);
        RspReady = 1'b1;
        @(posedge clk);
        #1;
        RspReady = 1'b0;
        check({tag, "_rspvalid_drop"}, {63'd0, RspValid}, 64'd0);
        check({tag, "_reqready_back"}, {63'd0, ReqReady}, 64'd1);
        check({tag, "_busy_drop"},     {63'd0, Busy},     64'd0);
    endtask

    task automatic txn(input string tag, input logic [55:0] pa, input logic [1:0] sz,
                       input logic [1:0] typ, input logic [1:0] priv,
                       input int exp_lat, input logic exp_match,
                       input logic [3:0] exp_entry, input logic exp_fault);
        issue(pa, sz, typ, priv);
        wait_rsp(lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_match"},   {63'd0, RspMatch}, {63'd0, exp_match});
        check({tag, "_entry"},   {60'd0, RspEntry}, {60'd0, exp_entry});
        check({tag, "_fault"},   {63'd0, RspFault}, {63'd0, exp_fault});
        check({tag, "_busy"},    {63'd0, Busy},     64'd1);
        check({tag, "_reqready"},{63'd0, ReqReady}, 64'd0);
        finish_rsp(tag);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        clk      = 1'b0;
        reset_n  = 1'b0;
        ReqValid = 1'b0;
        ReqPA    = 56'd0;
        ReqSize  = 2'b00;
        ReqType  = 2'b00;
        ReqPriv  = 2'b00;
        RspReady = 1'b0;
        clear_all();

        // Reset values
        #12;
        check("rst_reqready", {63'd0, ReqReady}, 64'd1);
        check("rst_rspvalid", {63'd0, RspValid}, 64'd0);
        check("rst_fault",    {63'd0, RspFault}, 64'd0);
        check("rst_match",    {63'd0, RspMatch}, 64'd0);
        check("rst_entry",    {60'd0, RspEntry}, 64'd0);
        check("rst_busy",     {63'd0, Busy},     64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // NAPOT 4 KiB at 0x80000000, R only, entry 3
        clear_all();
        set_entry(3, 8'h19, 54'h200001FF);
        txn("napot_u_rd",  56'h80000F00, 2'b10, 2'b00, 2'b00, 4, 1'b1, 4'd3, 1'b0);
        txn("napot_u_wr",  56'h80000F00, 2'b10, 2'b01, 2'b00, 4, 1'b1, 4'd3, 1'b1);
        txn("napot_u_ex",  56'h80000F00, 2'b10, 2'b10, 2'b00, 4, 1'b1, 4'd3, 1'b1);
        txn("napot_m_wr",  56'h80000F00, 2'b10, 2'b01, 2'b11, 4, 1'b1, 4'd3, 1'b0);
        set_entry(3, 8'h99, 54'h200001FF);
        txn("napot_ml_wr", 56'h80000F00, 2'b10, 2'b01, 2'b11, 4, 1'b1, 4'd3, 1'b1);
        txn("napot_ml_rd", 56'h80000F00, 2'b10, 2'b00, 2'b11, 4, 1'b1, 4'd3, 1'b0);

        // TOR [0x10000, 0x20000) in entry 1
        clear_all();
        set_entry(0, 8'h00, 54'h4000);
        set_entry(1, 8'h0F, 54'h8000);
        txn("tor_s_in",    56'h1FFFC,    2'b10, 2'b00, 2'b01, 2,  1'b1, 4'd1, 1'b0);
        txn("tor_s_out",   56'h20000,    2'b10, 2'b00, 2'b01, 16, 1'b0, 4'd0, 1'b1);
        txn("tor_s_below", 56'h0FFFC,    2'b10, 2'b00, 2'b01, 16, 1'b0, 4'd0, 1'b1);
        txn("tor_m_out",   56'h20000,    2'b10, 2'b00, 2'b11, 16, 1'b0, 4'd0, 1'b0);

        // Priority: entries 2 and 5 overlap
        clear_all();
        set_entry(2, 8'h1F, 54'h200001FF);
        set_entry(5, 8'h1F, 54'h200001FF);
        txn("prio",        56'h80000100, 2'b10, 2'b00, 2'b00, 3, 1'b1, 4'd2, 1'b0);

        // NA4 at 0xC-0xF, 8-byte access ignores bit 2
        clear_all();
        set_entry(0, 8'h11, 54'h3);
        txn("na4_sz3",     56'h8, 2'b11, 2'b00, 2'b00, 1,  1'b1, 4'd0, 1'b0);
        txn("na4_sz2_miss",56'h8, 2'b10, 2'b00, 2'b00, 16, 1'b0, 4'd0, 1'b1);
        txn("na4_sz2_hit", 56'hC, 2'b10, 2'b00, 2'b00, 1,  1'b1, 4'd0, 1'b0);

        // Backpressure: response held, new request ignored
        issue(56'h8, 2'b11, 2'b01, 2'b00);
        wait_rsp(lat);
        check("bp_latency", 64'(lat), 64'd1);
        ReqPA    = 56'h1234;
        ReqValid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_valid",    {63'd0, RspValid}, 64'd1);
            check("bp_fault",    {63'd0, RspFault}, 64'd1);
            check("bp_match",    {63'd0, RspMatch}, 64'd1);
            check("bp_entry",    {60'd0, RspEntry}, 64'd0);
            check("bp_busy",     {63'd0, Busy},     64'd1);
            check("bp_reqready", {63'd0, ReqReady}, 64'd0);
        end
        ReqValid = 1'b0;
        finish_rsp("bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_accept", {63'd0, Busy}, 64'd0);

        // Asynchronous reset mid-walk
        clear_all();
        set_entry(0, 8'h00, 54'h4000);
        set_entry(1, 8'h0F, 54'h8000);
        issue(56'h20000, 2'b10, 2'b00, 2'b01);
        repeat (5) @(posedge clk);
        #2;
        check("rw_busy_before", {63'd0, Busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("rw_rspvalid", {63'd0, RspValid}, 64'd0);
        check("rw_busy",     {63'd0, Busy},     64'd0);
        check("rw_reqready", {63'd0, ReqReady}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (RspValid) seen = 1'b1;
        end
        check("rw_no_stale", {63'd0, seen}, 64'd0);
        check("rw_idle_busy", {63'd0, Busy}, 64'd0);
        txn("post_reset",  56'h1FFFC, 2'b10, 2'b00, 2'b01, 2, 1'b1, 4'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmp_seq_checker.md
# pmp_seq_checker

Multi-cycle PMP permission checker that sits between the MMU's physical-address request path and the per-entry PMP address decode. It accepts one access request, walks the PMP entries in priority order (entry 0 first, one entry per cycle), and stops at the first matching entry or after the last entry. It then returns a fault/allow response and the matching entry index. It trades latency for area: a single per-entry decoder is time-shared instead of replicating decode logic for every entry.

## Interface
- PA_BITS, 56, physical address width.
- PMP_ENTRIES, 16, number of PMP entries; legal range 1..64.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request.
- ReqPA  in  PA_BITS  physical address.
- ReqSize  in  2  log2 access bytes (3 = 8-byte access).
- ReqType  in  2  00 read, 01 write, 10 execute; 11 is treated as read.
- ReqPriv  in  2  privilege mode; 11 = M.
- PMPCfgAll  in  8*PMP_ENTRIES  packed pmpcfg bytes; entry i at [8i+7:8i].
- PMPAdrAll  in  (PA_BITS-2)*PMP_ENTRIES  packed pmpaddr values; entry i at slice i.
- Busy  out  1  walk or response in progress; the CSR unit must stall PMP CSR writes while high.
- RspValid  out  1  response valid.
- RspReady  in  1  consumer accepts the response.
- RspFault  out  1  access-fault.
- RspMatch  out  1  an entry matched.
- RspEntry  out  clog2(PMP_ENTRIES), minimum 1 bit  index of the matching entry; 0 if no entry matched.

## Operation
- FSM states: IDLE, WALK, RESP. Reset enters IDLE.
- **IDLE**
  - ReqReady=1.
  - On ReqValid&ReqReady: capture PA/Size/Type/Priv, set Idx=0, PAgePrev=1, AnyActive=0, then go to WALK.
- **WALK**, per cycle, decode entry Idx using cfg[4:3] mode:
  - 00 OFF: entry never matches.
  - 01 TOR: match when PAgePrev and PA < {adr,2'b00}. Compare unsigned over the full PA_BITS.
  - 10 NA4 / 11 NAPOT:
    - Mask = ((adr + (mode==NAPOT)) ^ adr) concatenated with 2'b11.
    - Match when PA and {adr & ~mask, 00} agree on every bit outside Mask.
    - When ReqSize==3, bit 2 is also ignored.
  - At the edge:
    - PAgePrev <= (PA >= {adr,00}).
    - AnyActive |= (mode!=0).
    - Idx increments.
  - Exit on an active match (record Idx, L/X/W/R) or when Idx==PMP_ENTRIES-1 (no match). Go to RESP.
- **Fault rule**
  - Required bit: R for read, W for write, X for execute.
  - Match: fault = (ReqPriv!=M | L) & ~required bit.
  - No match: fault = (ReqPriv!=M) & (AnyActive | current entry active).
- **RESP**
  - RspValid=1. RspFault, RspMatch and RspEntry are registered and held stable.
  - On RspReady, go to IDLE.
- Busy=1 in WALK and RESP. ReqReady=0 outside IDLE.
- PMP CSR inputs are sampled live each WALK cycle. Stability is guaranteed by Busy.

## Timing
- Reset values: ReqReady=1, RspValid=0, RspFault=0, RspMatch=0, RspEntry=0, Busy=0.
- Request accepted at edge E0. If the first match is entry i, RspValid rises at edge E0+i+1. With no match, RspValid rises at E0+PMP_ENTRIES.
- Entries after the first match are never examined. Priority is the lowest index.
- RspValid stays high until RspReady is sampled high. The response leaves at that edge, and ReqReady=1 in the following cycle. There is no request/response overlap.
- reset_n low at any time aborts the walk asynchronously. No response is produced for the aborted request.
- ReqValid while not in IDLE is ignored. The requester holds the request until ReqReady.

## Test plan
- NAPOT/U-mode: entry 3 adr=0x200001FF, cfg=0x19 (4 KiB at 0x80000000, R only), entries 0-2 OFF.
  - Read PA 0x80000F00, Priv=00 -> RspMatch=1, RspEntry=3, RspFault=0, RspValid at E0+4.
  - Same PA, write -> RspFault=1.
- TOR: adr0=0x4000 cfg0=0x00, adr1=0x8000 cfg1=0x0F, others OFF.
  - S-mode read 0x1FFFC -> RspEntry=1, no fault.
  - S-mode read 0x20000 -> RspMatch=0, RspFault=1, RspValid at E0+16.
- M-mode:
  - No entry matches -> RspFault=0.
  - Unlocked NAPOT entry cfg=0x19, write -> RspFault=0.
  - Same entry locked, cfg=0x99, write -> RspFault=1.
- Priority and 8-byte NA4:
  - Entries 2 and 5 both cover PA -> RspEntry=2 at E0+3.
  - NA4 entry adr=0x3 (covers 0xC-0xF), Size=3, PA 0x8 -> RspMatch=1.
- Backpressure and reset:
  - Hold RspReady=0 for 10 cycles -> all Rsp* outputs stable and Busy=1. ReqValid held high is not accepted.
  - reset_n pulsed low mid-WALK -> RspValid=0, Busy=0, ReqReady=1 immediately, and no stale response afterwards.
